// File: rtl/id_control_issue.sv
// Decode/issue stage: turns an IF/ID instruction into the registered ID/EX control bundle,
// inserting load-use bubbles and honouring EX flushes.
module id_control_issue #(
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic        flush,
  output logic [16:0] control_signals,
  output logic        ctrl_valid,
  output logic [4:0]  rs_out,
  output logic [4:0]  rt_out,
  output logic [4:0]  dest_out,
  output logic [15:0] imm16_out,
  output logic        stall
);

  localparam logic [2:0] SRC_RT = 3'b000, SRC_SX = 3'b001, SRC_ZX = 3'b010,
                         SRC_HI = 3'b011, SRC_PC8 = 3'b100;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                         ALU_OR = 3'b011, ALU_SLT = 3'b100, ALU_PASSB = 3'b101;
  localparam logic [1:0] SZ_B = 2'b00, SZ_W = 2'b10;
  localparam logic Y = 1'b1, N = 1'b0;

  typedef enum logic {ST_ISSUE, ST_STALL} state_t;

  function automatic logic [16:0] ctrl_word(
    input logic [2:0] src, input logic [2:0] alu, input logic ld, input logic rf,
    input logic br, input logic mw, input logic [1:0] sz, input logic sg,
    input logic rdst, input logic jp, input logic lk);
    return {src, alu, ld, rf, br, mw, sz, sg, rdst, jp, lk, 1'b0};
  endfunction

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_dest;
  logic [16:0] w_ctrl;
  logic        w_rd_rs, w_rd_rt, w_hazard, w_accept;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [4:0]  r_ld_dest;
  logic [16:0] r_ctrl;
  logic        r_valid, r_stall;
  logic [4:0]  r_rs, r_rt, r_dest;
  logic [15:0] r_imm;

  assign w_op    = instr[31:26];
  assign w_funct = instr[5:0];
  assign w_rs    = instr[25:21];
  assign w_rt    = instr[20:16];
  assign w_rd    = instr[15:11];

  always_comb begin
    w_ctrl  = '0;
    w_dest  = '0;
    w_rd_rs = Y;
    w_rd_rt = N;
    case (w_op)
      6'h00: begin
        w_dest  = w_rd;
        w_rd_rt = Y;
        case (w_funct)
          6'h21: w_ctrl = ctrl_word(SRC_RT, ALU_ADD, N, Y, N, N, SZ_B, N, Y, N, N);
          6'h23: w_ctrl = ctrl_word(SRC_RT, ALU_SUB, N, Y, N, N, SZ_B, N, Y, N, N);
          6'h24: w_ctrl = ctrl_word(SRC_RT, ALU_AND, N, Y, N, N, SZ_B, N, Y, N, N);
          6'h25: w_ctrl = ctrl_word(SRC_RT, ALU_OR,  N, Y, N, N, SZ_B, N, Y, N, N);
          6'h2A: w_ctrl = ctrl_word(SRC_RT, ALU_SLT, N, Y, N, N, SZ_B, N, Y, N, N);
          default: w_ctrl = '0;
        endcase
      end
      6'h09: begin w_ctrl = ctrl_word(SRC_SX, ALU_ADD, N, Y, N, N, SZ_B, N, N, N, N); w_dest = w_rt; end
      6'h0C: begin w_ctrl = ctrl_word(SRC_ZX, ALU_AND, N, Y, N, N, SZ_B, N, N, N, N); w_dest = w_rt; end
      6'h0D: begin w_ctrl = ctrl_word(SRC_ZX, ALU_OR,  N, Y, N, N, SZ_B, N, N, N, N); w_dest = w_rt; end
      6'h0F: begin
        w_ctrl  = ctrl_word(SRC_HI, ALU_PASSB, N, Y, N, N, SZ_B, N, N, N, N);
        w_dest  = w_rt;
        w_rd_rs = N;
      end
      6'h23: begin w_ctrl = ctrl_word(SRC_SX, ALU_ADD, Y, Y, N, N, SZ_W, Y, N, N, N); w_dest = w_rt; end
      6'h20: begin w_ctrl = ctrl_word(SRC_SX, ALU_ADD, Y, Y, N, N, SZ_B, Y, N, N, N); w_dest = w_rt; end
      6'h24: begin w_ctrl = ctrl_word(SRC_SX, ALU_ADD, Y, Y, N, N, SZ_B, N, N, N, N); w_dest = w_rt; end
      6'h2B: begin w_ctrl = ctrl_word(SRC_SX, ALU_ADD, N, N, N, Y, SZ_W, N, N, N, N); w_rd_rt = Y; end
      6'h28: begin w_ctrl = ctrl_word(SRC_SX, ALU_ADD, N, N, N, Y, SZ_B, N, N, N, N); w_rd_rt = Y; end
      6'h04, 6'h05: begin
        w_ctrl  = ctrl_word(SRC_RT, ALU_SUB, N, N, Y, N, SZ_B, N, N, N, N);
        w_rd_rt = Y;
      end
      6'h02: begin w_ctrl = ctrl_word(SRC_RT, ALU_ADD, N, N, N, N, SZ_B, N, N, Y, N); w_rd_rs = N; end
      6'h03: begin
        w_ctrl  = ctrl_word(SRC_PC8, ALU_ADD, N, Y, N, N, SZ_B, N, N, Y, Y);
        w_dest  = 5'd31;
        w_rd_rs = N;
      end
      default: w_ctrl = '0;
    endcase
  end

  // Loads write rt without reading it, so only real source reads can collide.
  assign w_hazard = (r_ld_dest != 5'd0) &&
                    ((w_rd_rs && (w_rs == r_ld_dest)) || (w_rd_rt && (w_rt == r_ld_dest)));
  assign instr_ready = (r_state == ST_ISSUE) && !w_hazard && !flush;
  assign w_accept    = instr_valid && instr_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_ISSUE;
      r_cnt     <= '0;
      r_ld_dest <= '0;
      r_ctrl    <= '0;
      r_valid   <= 1'b0;
      r_stall   <= 1'b0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_dest    <= '0;
      r_imm     <= '0;
    end else begin
      // Bubble unless an instruction is issued this edge.
      r_ctrl    <= '0;
      r_valid   <= 1'b0;
      r_ld_dest <= '0;
      if (flush) begin
        r_state <= ST_ISSUE;
        r_stall <= 1'b0;
      end else begin
        case (r_state)
          ST_ISSUE: begin
            if (instr_valid && w_hazard) begin
              r_state <= ST_STALL;
              r_cnt   <= 2'(LOAD_USE_BUBBLES - 1);
              r_stall <= 1'b1;
            end else if (w_accept) begin
              r_ctrl    <= w_ctrl;
              r_valid   <= 1'b1;
              r_rs      <= w_rs;
              r_rt      <= w_rt;
              r_dest    <= w_dest;
              r_imm     <= instr[15:0];
              r_ld_dest <= w_ctrl[10] ? w_dest : 5'd0;
            end
          end
          ST_STALL: begin
            if (r_cnt == 2'd0) begin
              r_state <= ST_ISSUE;
              r_stall <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 2'd1;
            end
          end
          default: r_state <= ST_ISSUE;
        endcase
      end
    end
  end

  assign control_signals = r_ctrl;
  assign ctrl_valid      = r_valid;
  assign rs_out          = r_rs;
  assign rt_out          = r_rt;
  assign dest_out        = r_dest;
  assign imm16_out       = r_imm;
  assign stall           = r_stall;

endmodule

// File: tb/tb_id_control_issue.sv
// Bench for id_control_issue: decode table through a scoreboard, then hand-written
// load-use, flush and asynchronous-reset sequences on 1- and 3-bubble instances.
module tb_id_control_issue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, instr_valid, flush;
  logic [31:0] instr;

  logic        a_ready, a_valid, a_stall, b_ready, b_valid, b_stall;
  logic [16:0] a_ctrl, b_ctrl;
  logic [4:0]  a_rs, a_rt, a_dest, b_rs, b_rt, b_dest;
  logic [15:0] a_imm, b_imm;

  id_control_issue #(.LOAD_USE_BUBBLES(1)) dut1 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(a_ready), .flush(flush), .control_signals(a_ctrl), .ctrl_valid(a_valid),
    .rs_out(a_rs), .rt_out(a_rt), .dest_out(a_dest), .imm16_out(a_imm), .stall(a_stall));

  id_control_issue #(.LOAD_USE_BUBBLES(3)) dut3 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(b_ready), .flush(flush), .control_signals(b_ctrl), .ctrl_valid(b_valid),
    .rs_out(b_rs), .rt_out(b_rt), .dest_out(b_dest), .imm16_out(b_imm), .stall(b_stall));

  typedef struct { logic [31:0] ins; logic [16:0] ctrl; logic [4:0] dest; } vec_t;
  typedef struct { logic [16:0] ctrl; logic [4:0] dest; logic [4:0] rs; logic [4:0] rt; logic [15:0] imm; } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   sb_en = 1'b0;
  vec_t tbl[19];

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] f);
    return {6'h00, rs, rt, rd, 5'd0, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_en && !reset && a_valid) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got ctrl 0x%0h expected no output", a_ctrl);
      end else begin
        e = sbq.pop_front();
        chk("sb_ctrl", a_ctrl, e.ctrl);
        chk("sb_dest", a_dest, e.dest);
        chk("sb_rs", a_rs, e.rs);
        chk("sb_rt", a_rt, e.rt);
        chk("sb_imm", a_imm, e.imm);
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input logic [16:0] ctrl, input logic [4:0] dest);
    exp_t e;
    int   w;
    @(negedge clk);
    instr_valid = 1'b1;
    instr = ins;
    #1;
    w = 0;
    while (!a_ready && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (!a_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: ready 0 expected 1 for instr 0x%0h", ins);
    end else begin
      e.ctrl = ctrl;
      e.dest = dest;
      e.rs   = ins[25:21];
      e.rt   = ins[20:16];
      e.imm  = ins[15:0];
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    instr_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    tbl[0]  = '{rtype(5'd1, 5'd2, 5'd3, 6'h21),     17'h00208, 5'd3};
    tbl[1]  = '{rtype(5'd1, 5'd2, 5'd4, 6'h23),     17'h00A08, 5'd4};
    tbl[2]  = '{rtype(5'd6, 5'd7, 5'd5, 6'h24),     17'h01208, 5'd5};
    tbl[3]  = '{rtype(5'd9, 5'd10, 5'd8, 6'h25),    17'h01A08, 5'd8};
    tbl[4]  = '{rtype(5'd12, 5'd13, 5'd11, 6'h2A),  17'h02208, 5'd11};
    tbl[5]  = '{itype(6'h09, 5'd0, 5'd7, 16'h0001), 17'h04200, 5'd7};
    tbl[6]  = '{itype(6'h0C, 5'd1, 5'd9, 16'hFFFF), 17'h09200, 5'd9};
    tbl[7]  = '{itype(6'h0D, 5'd2, 5'd10, 16'h00F0), 17'h09A00, 5'd10};
    tbl[8]  = '{itype(6'h0F, 5'd0, 5'd11, 16'h1234), 17'h0EA00, 5'd11};
    tbl[9]  = '{itype(6'h23, 5'd1, 5'd20, 16'h0004), 17'h04650, 5'd20};
    tbl[10] = '{itype(6'h20, 5'd2, 5'd21, 16'hFFFC), 17'h04610, 5'd21};
    tbl[11] = '{itype(6'h24, 5'd3, 5'd22, 16'h0008), 17'h04600, 5'd22};
    tbl[12] = '{itype(6'h2B, 5'd1, 5'd2, 16'h0010), 17'h040C0, 5'd0};
    tbl[13] = '{itype(6'h28, 5'd3, 5'd4, 16'h0001), 17'h04080, 5'd0};
    tbl[14] = '{itype(6'h04, 5'd1, 5'd2, 16'hFFFE), 17'h00900, 5'd0};
    tbl[15] = '{itype(6'h05, 5'd3, 5'd4, 16'h0005), 17'h00900, 5'd0};
    tbl[16] = '{{6'h02, 26'h0000040},               17'h00004, 5'd0};
    tbl[17] = '{{6'h03, 26'h0000100},               17'h10206, 5'd31};
    tbl[18] = '{itype(6'h3F, 5'd1, 5'd2, 16'h0005), 17'h00000, 5'd0};

    reset = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", a_ctrl, 17'h0);
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_stall", a_stall, 1'b0);
    chk("rst_dest", a_dest, 5'd0);
    reset = 1'b0;
    #1;
    chk("rst_ready", a_ready, 1'b1);

    // Decode table through the scoreboard
    sb_en = 1'b1;
    for (int i = 0; i < 19; i++) issue(tbl[i].ins, tbl[i].ctrl, tbl[i].dest);
    repeat (3) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    sb_en = 1'b0;

    // Load-use with one bubble
    do_reset();
    instr = itype(6'h23, 5'd1, 5'd5, 16'd4);
    instr_valid = 1'b1;
    #1;
    chk("lw_ready", a_ready, 1'b1);
    step();
    chk("lw_ctrl", a_ctrl, 17'h04650);
    chk("lw_dest", a_dest, 5'd5);
    instr = rtype(5'd5, 5'd2, 5'd6, 6'h21);
    #1;
    chk("hz_ready", a_ready, 1'b0);
    step();
    chk("hz_valid", a_valid, 1'b0);
    chk("hz_stall", a_stall, 1'b1);
    chk("hz_ready_stall", a_ready, 1'b0);
    w = 0;
    while (!a_ready && w < 10) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("hz_resume", a_ready, 1'b1);
    step();
    chk("hz_addu_ctrl", a_ctrl, 17'h00208);
    chk("hz_addu_dest", a_dest, 5'd6);
    chk("hz_addu_valid", a_valid, 1'b1);
    chk("hz_addu_stall", a_stall, 1'b0);

    // Independent follower, load-after-load, dependent store, flush in ISSUE
    do_reset();
    instr = itype(6'h23, 5'd1, 5'd5, 16'd4);
    instr_valid = 1'b1;
    step();
    instr = itype(6'h09, 5'd0, 5'd7, 16'd1);
    #1;
    chk("indep_ready", a_ready, 1'b1);
    step();
    chk("indep_ctrl", a_ctrl, 17'h04200);
    chk("indep_stall", a_stall, 1'b0);
    instr = itype(6'h23, 5'd1, 5'd5, 16'd0);
    step();
    instr = itype(6'h23, 5'd1, 5'd5, 16'd4);
    #1;
    chk("lwlw_ready", a_ready, 1'b1);
    step();
    chk("lwlw_ctrl", a_ctrl, 17'h04650);
    instr = itype(6'h2B, 5'd1, 5'd5, 16'd0);
    #1;
    chk("st_hz_ready", a_ready, 1'b0);
    flush = 1'b1;
    #1;
    chk("fl_ready", a_ready, 1'b0);
    step();
    chk("fl_valid", a_valid, 1'b0);
    chk("fl_stall", a_stall, 1'b0);
    flush = 1'b0;
    #1;
    chk("fl_post_ready", a_ready, 1'b1);
    step();
    chk("fl_sw_ctrl", a_ctrl, 17'h040C0);
    chk("fl_sw_valid", a_valid, 1'b1);

    // Three-bubble instance: flush on the second bubble
    do_reset();
    instr = itype(6'h23, 5'd1, 5'd5, 16'd4);
    instr_valid = 1'b1;
    step();
    chk("b_lw_ctrl", b_ctrl, 17'h04650);
    instr = rtype(5'd5, 5'd2, 5'd6, 6'h21);
    #1;
    chk("b_hz_ready", b_ready, 1'b0);
    step();
    chk("b_bub1_stall", b_stall, 1'b1);
    chk("b_bub1_valid", b_valid, 1'b0);
    step();
    chk("b_bub2_stall", b_stall, 1'b1);
    chk("b_bub2_ready", b_ready, 1'b0);
    flush = 1'b1;
    #1;
    chk("b_fl_ready", b_ready, 1'b0);
    step();
    chk("b_fl_stall", b_stall, 1'b0);
    chk("b_fl_valid", b_valid, 1'b0);
    flush = 1'b0;
    #1;
    chk("b_fl_post_ready", b_ready, 1'b1);
    step();
    chk("b_addu_valid", b_valid, 1'b1);
    chk("b_addu_dest", b_dest, 5'd6);
    chk("b_addu_ctrl", b_ctrl, 17'h00208);

    // Asynchronous reset in the middle of a stall
    do_reset();
    instr = itype(6'h23, 5'd1, 5'd5, 16'd4);
    instr_valid = 1'b1;
    step();
    instr = rtype(5'd5, 5'd2, 5'd6, 6'h21);
    step();
    chk("ar_stall", a_stall, 1'b1);
    chk("ar_hold_dest", a_dest, 5'd5);
    chk("ar_hold_rs", a_rs, 5'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_stall0", a_stall, 1'b0);
    chk("ar_ctrl0", a_ctrl, 17'h0);
    chk("ar_valid0", a_valid, 1'b0);
    chk("ar_dest0", a_dest, 5'd0);
    chk("ar_rs0", a_rs, 5'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ar_ready", a_ready, 1'b1);
    step();
    chk("ar_addu_valid", a_valid, 1'b1);
    chk("ar_addu_dest", a_dest, 5'd6);
    instr_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
